// File: rtl/det_pkg.sv
// Shared definitions for the determinant / permanent engine.
//   state_t    : controller state encoding
//   clog2      : ceiling log2 usable in parameter expressions
//   fact       : integer factorial
//   addr_width : clog2 clamped to at least one bit (for port widths)
//   acc_width  : accumulator width that holds any sum of n! products of n elements
package det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_PERM,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int fact(input int v);
        int f;
        f = 1;
        for (int k = 2; k <= v; k++) f = f * k;
        return f;
    endfunction

    function automatic int addr_width(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    // n products of DW-bit signed values need n*DW bits; summing n! of them
    // adds clog2(n!) bits of growth.
    function automatic int acc_width(input int dw, input int maxn);
        return maxn * dw + clog2(fact(maxn));
    endfunction

endpackage

// File: rtl/det_engine_perm_gen.sv
// Permutation generator: iterative Heap's algorithm, one step per cycle.
//   clk, reset : clock, synchronous active-high reset
//   init       : restart at the identity permutation with sign +1
//   step       : advance the algorithm by one step (ignored once done)
//   n          : matrix order in use
//   swapped    : this step performs a swap (a new permutation follows)
//   done       : Heap index has reached n; every permutation was produced
//   perm       : current permutation, perm[k] = p(k)
//   sign       : parity of the current permutation (1 = odd, i.e. -1)
module perm_gen
    import det_pkg::*;
#(
    parameter  int MAXN = 4,
    localparam int AW   = addr_width(MAXN),
    localparam int NW   = addr_width(MAXN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     step,
    input  logic [NW-1:0]            n,
    output logic                     swapped,
    output logic                     done,
    output logic [MAXN-1:0][AW-1:0]  perm,
    output logic                     sign
);

    logic [MAXN-1:0][AW-1:0] r_p;
    logic [MAXN-1:0][NW-1:0] r_c;
    logic [NW-1:0]           r_idx;
    logic                    r_sign;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_other;
    logic          w_can_swap;

    // r_idx < n <= MAXN whenever it is used as an index, so truncation is safe.
    assign w_idx      = r_idx[AW-1:0];
    assign w_can_swap = (r_c[w_idx] < r_idx);
    // Even Heap index swaps with position 0, odd index with position c[idx].
    assign w_other    = r_idx[0] ? r_c[w_idx][AW-1:0] : '0;

    assign done    = (r_idx >= n);
    assign swapped = step && !done && w_can_swap;
    assign perm    = r_p;
    assign sign    = r_sign;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            for (int k = 0; k < MAXN; k++) r_p[k] <= AW'(k);
            r_c    <= '0;
            r_idx  <= NW'(1);
            r_sign <= 1'b0;
        end else if (step && !done) begin
            if (w_can_swap) begin
                r_p[w_other] <= r_p[w_idx];
                r_p[w_idx]   <= r_p[w_other];
                r_c[w_idx]   <= r_c[w_idx] + NW'(1);
                r_idx        <= NW'(1);
                r_sign       <= ~r_sign;
            end else begin
                r_c[w_idx] <= '0;
                r_idx      <= r_idx + NW'(1);
            end
        end
    end

endmodule

// File: rtl/det_engine.sv
// Determinant / permanent engine: walks all n! permutations, fetching one
// matrix element per cycle and accumulating signed products.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request pulse, accepted in IDLE or DONE
//   mode        : 0 = determinant, 1 = permanent (captured at start)
//   n_in        : matrix order (captured at start)
//   read_data   : element a[i][j], valid in the cycle read is high
//   i, j        : element address (0 when read is low)
//   read        : element fetch strobe
//   write       : one-cycle result strobe
//   write_data  : signed result while write is high, else 0
//   busy        : computation in progress
//   finish      : result delivered, held until next start or reset
//   error       : order was illegal (valid with finish)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// ACCUM    | fetching a[k][p(k)], building the product of one permutation
// PERM     | one Heap's-algorithm step per cycle until the next swap / end
// WRITE    | presenting the accumulated result for one cycle
// DONE     | finished; holds finish/error, accepts a new start
module det_engine
    import det_pkg::*;
#(
    parameter  int DW    = 16,
    parameter  int MAXN  = 4,
    localparam int AW    = addr_width(MAXN),
    localparam int NW    = addr_width(MAXN + 1),
    localparam int ACC_W = acc_width(DW, MAXN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [NW-1:0]           n_in,
    input  logic signed [DW-1:0]    read_data,
    output logic [AW-1:0]           i,
    output logic [AW-1:0]           j,
    output logic                    read,
    output logic                    write,
    output logic signed [ACC_W-1:0] write_data,
    output logic                    busy,
    output logic                    finish,
    output logic                    error
);

    state_t r_state;
    state_t w_next;

    logic [NW-1:0]           r_n;
    logic                    r_mode;
    logic                    r_err;
    logic [AW-1:0]           r_k;
    logic signed [ACC_W-1:0] r_prod;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_init;
    logic                    w_step;
    logic                    w_swapped;
    logic                    w_done;
    logic                    w_sign;
    logic [MAXN-1:0][AW-1:0] w_perm;
    logic                    w_n_legal;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_elem;
    logic signed [ACC_W-1:0] w_term;

    perm_gen #(.MAXN(MAXN)) u_perm (
        .clk     (clk),
        .reset   (reset),
        .init    (w_init),
        .step    (w_step),
        .n       (r_n),
        .swapped (w_swapped),
        .done    (w_done),
        .perm    (w_perm),
        .sign    (w_sign)
    );

    assign w_n_legal = (n_in != '0) && (n_in <= NW'(MAXN));
    assign w_last    = (NW'(r_k) == (r_n - NW'(1)));
    assign w_elem    = {{(ACC_W-DW){read_data[DW-1]}}, read_data};
    assign w_term    = r_prod * w_elem;

    assign i          = read  ? r_k         : '0;
    assign j          = read  ? w_perm[r_k] : '0;
    assign write_data = write ? r_acc       : '0;
    assign error      = finish && r_err;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        read   = 1'b0;
        write  = 1'b0;
        busy   = 1'b0;
        finish = 1'b0;
        w_init = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                finish = (r_state == ST_DONE);
                if (start) begin
                    w_init = 1'b1;
                    w_next = w_n_legal ? ST_ACCUM : ST_WRITE;
                end
            end
            ST_ACCUM: begin
                read = 1'b1;
                busy = 1'b1;
                if (w_last) w_next = ST_PERM;
            end
            ST_PERM: begin
                busy = 1'b1;
                if (w_done) begin
                    w_next = ST_WRITE;
                end else begin
                    w_step = 1'b1;
                    if (w_swapped) w_next = ST_ACCUM;
                end
            end
            ST_WRITE: begin
                busy   = 1'b1;
                write  = 1'b1;
                w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n    <= '0;
            r_mode <= 1'b0;
            r_err  <= 1'b0;
            r_k    <= '0;
            r_prod <= ACC_W'(1);
            r_acc  <= '0;
        end else if (w_init) begin
            r_n    <= n_in;
            r_mode <= mode;
            r_err  <= !w_n_legal;
            r_k    <= '0;
            r_prod <= ACC_W'(1);
            r_acc  <= '0;
        end else if (r_state == ST_ACCUM) begin
            if (w_last) begin
                // Permanent ignores the permutation parity.
                if (w_sign && !r_mode) r_acc <= r_acc - w_term;
                else                   r_acc <= r_acc + w_term;
            end else begin
                r_prod <= w_term;
                r_k    <= r_k + AW'(1);
            end
        end else if (w_swapped) begin
            r_k    <= '0;
            r_prod <= ACC_W'(1);
        end
    end

endmodule
